// File: rtl/j1_soc_pkg.sv
// j1_soc_pkg: shared definitions for the J1 system-on-chip.
//   - instruction class codes (insn[14:13] when insn[15]=0)
//   - ALU opcode enum (insn[11:8] of an ALU instruction)
//   - I/O address map
//   - stack depth / pointer width and a stack-delta helper
//   - UART FSM state enums
package j1_soc_pkg;

  typedef enum logic [1:0] {
    CLS_JUMP  = 2'd0,
    CLS_CJUMP = 2'd1,
    CLS_CALL  = 2'd2,
    CLS_ALU   = 2'd3
  } insn_cls_e;

  typedef enum logic [3:0] {
    ALU_T, ALU_N, ALU_ADD, ALU_AND, ALU_OR, ALU_XOR, ALU_INV, ALU_EQ,
    ALU_SLT, ALU_RSH, ALU_DEC, ALU_R, ALU_MEM, ALU_LSH, ALU_DEPTH, ALU_ULT
  } alu_op_e;

  localparam logic [15:0] IO_LED       = 16'h8000;
  localparam logic [15:0] IO_UART_TX   = 16'h8002;
  localparam logic [15:0] IO_UART_STAT = 16'h8004;
  localparam logic [15:0] IO_UART_DATA = 16'h8006;

  localparam int STACK_DEPTH = 32;
  localparam int SP_W        = 5;

  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // Sign-extend a 2-bit stack delta to the pointer width; pointers wrap.
  function automatic logic [SP_W-1:0] sp_delta(input logic [1:0] d);
    return {{(SP_W-2){d[1]}}, d};
  endfunction

endpackage

// File: rtl/j1_core.sv
// j1_core: J1-style 16-bit stack CPU, one instruction per clock.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   code_addr_o [12:0]  word address of the instruction being executed (pc)
//   insn_i      [15:0]  instruction word, read combinationally
//   bus_addr_o  [15:0]  data address (always T, byte address)
//   bus_wdata_o [15:0]  store data (always N)
//   bus_we_o            store strobe, committed on the clock edge
//   bus_re_o            read strobe for the [T] ALU op (side-effecting I/O reads)
//   bus_rdata_i [15:0]  combinational read data for address T
// Bus protocol: there is no handshake; every access completes in the cycle
// its strobe is high, and the slave must answer combinationally.
module j1_core
  import j1_soc_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [12:0] code_addr_o,
  input  logic [15:0] insn_i,
  output logic [15:0] bus_addr_o,
  output logic [15:0] bus_wdata_o,
  output logic        bus_we_o,
  output logic        bus_re_o,
  input  logic [15:0] bus_rdata_i
);

  logic [12:0]     pc_q, pc_d, pc_plus1;
  logic [SP_W-1:0] dsp_q, dsp_d, rsp_q, rsp_d;
  logic [15:0]     t_q, t_d;
  logic [15:0]     dstack_mem [STACK_DEPTH];
  logic [15:0]     rstack_mem [STACK_DEPTH];
  logic [15:0]     n, r, alu_res, r_wdata;
  logic            d_we, r_we, we;
  alu_op_e         alu_op;
  insn_cls_e       cls;
  logic            unused_bits;

  // N and R live in the stack memories at the current pointers.
  assign n        = dstack_mem[dsp_q];
  assign r        = rstack_mem[rsp_q];
  assign pc_plus1 = pc_q + 13'd1;
  assign alu_op   = alu_op_e'(insn_i[11:8]);
  assign cls      = insn_cls_e'(insn_i[14:13]);

  always_comb begin
    alu_res = t_q;
    case (alu_op)
      ALU_T:     alu_res = t_q;
      ALU_N:     alu_res = n;
      ALU_ADD:   alu_res = t_q + n;
      ALU_AND:   alu_res = t_q & n;
      ALU_OR:    alu_res = t_q | n;
      ALU_XOR:   alu_res = t_q ^ n;
      ALU_INV:   alu_res = ~t_q;
      ALU_EQ:    alu_res = (n == t_q) ? 16'hFFFF : 16'h0000;
      ALU_SLT:   alu_res = ($signed(n) < $signed(t_q)) ? 16'hFFFF : 16'h0000;
      ALU_RSH:   alu_res = n >> t_q[3:0];
      ALU_DEC:   alu_res = t_q - 16'd1;
      ALU_R:     alu_res = r;
      ALU_MEM:   alu_res = bus_rdata_i;
      ALU_LSH:   alu_res = n << t_q[3:0];
      ALU_DEPTH: alu_res = 16'({rsp_q, dsp_q});
      ALU_ULT:   alu_res = (n < t_q) ? 16'hFFFF : 16'h0000;
    endcase
  end

  always_comb begin
    pc_d     = pc_plus1;
    dsp_d    = dsp_q;
    rsp_d    = rsp_q;
    t_d      = t_q;
    d_we     = 1'b0;
    r_we     = 1'b0;
    r_wdata  = t_q;
    we       = 1'b0;
    bus_re_o = 1'b0;
    if (insn_i[15]) begin
      t_d   = {1'b0, insn_i[14:0]};
      dsp_d = dsp_q + SP_W'(1);
      d_we  = 1'b1;
    end else begin
      case (cls)
        CLS_JUMP: pc_d = insn_i[12:0];
        CLS_CJUMP: begin
          if (t_q == 16'h0000) pc_d = insn_i[12:0];
          dsp_d = dsp_q - SP_W'(1);
          t_d   = n;
        end
        CLS_CALL: begin
          rsp_d   = rsp_q + SP_W'(1);
          r_we    = 1'b1;
          r_wdata = {3'b000, pc_plus1};
          pc_d    = insn_i[12:0];
        end
        CLS_ALU: begin
          t_d      = alu_res;
          dsp_d    = dsp_q + sp_delta(insn_i[1:0]);
          rsp_d    = rsp_q + sp_delta(insn_i[3:2]);
          d_we     = insn_i[7];
          r_we     = insn_i[6];
          we       = insn_i[5];
          bus_re_o = (alu_op == ALU_MEM);
          if (insn_i[12]) pc_d = r[12:0];
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q  <= '0;
      dsp_q <= '0;
      rsp_q <= '0;
      t_q   <= '0;
    end else begin
      pc_q  <= pc_d;
      dsp_q <= dsp_d;
      rsp_q <= rsp_d;
      t_q   <= t_d;
      // Pushed values land at the new pointer so they become the new N / R.
      if (d_we) dstack_mem[dsp_d] <= t_q;
      if (r_we) rstack_mem[rsp_d] <= r_wdata;
    end
  end

  assign code_addr_o = pc_q;
  assign bus_addr_o  = t_q;
  assign bus_wdata_o = n;
  assign bus_we_o    = we & ~rst_i;

  // insn[4] has no meaning; return addresses only need 13 bits.
  assign unused_bits = ^{insn_i[4], r[15:13]};

endmodule

// File: rtl/j1_soc.sv
// j1_soc: J1 CPU + unified program/data RAM + LED register + 8N1 UART.
// Ports:
//   sys_clk_i  system clock (rising edge)
//   sys_rst_i  synchronous active-high reset
//   uart_tx    UART transmit line, idle high
//   uart_rx    UART receive line, idle high
//   ledout     LED register bit 0
// Build option: define J1SOC_UART_RX_EN to include the UART receiver;
// without it uart_rx is ignored and the receive status/data read as 0.
module j1_soc
  import j1_soc_pkg::*;
#(
  parameter int    MEM_WORDS    = 4096,
  parameter string MEM_INIT     = "j1.hex",
  parameter int    CLKS_PER_BIT = 434
)(
  input  logic sys_clk_i,
  input  logic sys_rst_i,
  output logic uart_tx,
  input  logic uart_rx,
  output logic ledout
);

  localparam int          AW       = $clog2(MEM_WORDS);
  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  logic [15:0] mem [MEM_WORDS];
  logic [12:0] code_addr;
  logic [15:0] insn, bus_addr, bus_wdata, bus_rdata, io_rdata;
  logic        bus_we, bus_re;
  logic        led_q, tx_busy, tx_start, rx_valid, unused_sink;
  logic [7:0]  rx_data;
  tx_state_e   tx_state_q;
  logic [9:0]  tx_shift_q;
  logic [15:0] tx_cnt_q;
  logic [3:0]  tx_bit_q;

  j1_core u_core (
    .clk_i       (sys_clk_i),
    .rst_i       (sys_rst_i),
    .code_addr_o (code_addr),
    .insn_i      (insn),
    .bus_addr_o  (bus_addr),
    .bus_wdata_o (bus_wdata),
    .bus_we_o    (bus_we),
    .bus_re_o    (bus_re),
    .bus_rdata_i (bus_rdata)
  );

  assign insn = mem[code_addr[AW-1:0]];

  // T[15] selects I/O; RAM is word-indexed from the byte address.
  always_ff @(posedge sys_clk_i) begin
    if (bus_we && !bus_addr[15]) mem[bus_addr[AW:1]] <= bus_wdata;
  end

  always_comb begin
    io_rdata = '0;
    case (bus_addr)
      IO_LED:       io_rdata = {15'b0, led_q};
      IO_UART_STAT: io_rdata = {14'b0, rx_valid, tx_busy};
      IO_UART_DATA: io_rdata = {8'b0, rx_data};
      default:      io_rdata = '0;
    endcase
  end

  assign bus_rdata = bus_addr[15] ? io_rdata : mem[bus_addr[AW:1]];

  assign tx_busy  = (tx_state_q == TX_BUSY);
  assign tx_start = bus_we && (bus_addr == IO_UART_TX) && !tx_busy;

  // LED register and UART transmitter. The line is the LSB of a shift
  // register that holds {stop, data, start} and refills with ones.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      led_q      <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_shift_q <= '1;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
    end else begin
      if (bus_we && bus_addr == IO_LED) led_q <= bus_wdata[0];
      case (tx_state_q)
        TX_IDLE: begin
          if (tx_start) begin
            tx_shift_q <= {1'b1, bus_wdata[7:0], 1'b0};
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_state_q <= TX_BUSY;
          end
        end
        TX_BUSY: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 4'd9) begin
              tx_shift_q <= '1;
              tx_state_q <= TX_IDLE;
            end else begin
              tx_shift_q <= {1'b1, tx_shift_q[9:1]};
              tx_bit_q   <= tx_bit_q + 4'd1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
          end
        end
      endcase
    end
  end

  assign uart_tx = tx_shift_q[0];
  assign ledout  = led_q;

`ifdef J1SOC_UART_RX_EN
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]  rx_sync_q;
  rx_state_e   rx_state_q;
  logic [15:0] rx_cnt_q;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_shift_q, rx_data_q;
  logic        rx_valid_q, rx_in, rx_rd;

  assign rx_in = rx_sync_q[1];
  assign rx_rd = bus_re && (bus_addr == IO_UART_DATA);

  // Receiver: a low line is re-checked half a bit later to reject glitches,
  // then every bit (including stop) is sampled one bit period apart.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      rx_sync_q  <= 2'b11;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_sync_q <= {rx_sync_q[0], uart_rx};
      if (rx_rd) rx_valid_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          rx_cnt_q <= '0;
          if (!rx_in) rx_state_q <= RX_START;
        end
        RX_START: begin
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_in ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_in, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == BIT_LAST) begin
            // A new byte wins over a same-cycle read clear.
            if (rx_in) begin
              rx_data_q  <= rx_shift_q;
              rx_valid_q <= 1'b1;
            end
            rx_state_q <= RX_IDLE;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
      endcase
    end
  end

  assign rx_valid    = rx_valid_q;
  assign rx_data     = rx_data_q;
  assign unused_sink = ^code_addr;
`else
  assign rx_valid    = 1'b0;
  assign rx_data     = 8'h00;
  assign unused_sink = ^{code_addr, uart_rx, bus_re};
`endif

endmodule

// File: tb/tb_j1_soc.sv
// tb_j1_soc: directed bench for j1_soc. Programs are placed in RAM through
// the hierarchy while reset is held; expected values are hand-computed.
module tb_j1_soc;

  localparam int MEM_WORDS = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_rx = 1'b1;
  logic uart_tx, ledout;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] prog [32];
  logic [15:0] exp_q [$];

  j1_soc #(
    .MEM_WORDS    (MEM_WORDS),
    .MEM_INIT     (""),
    .CLKS_PER_BIT (4)
  ) dut (
    .sys_clk_i (clk),
    .sys_rst_i (rst),
    .uart_tx   (uart_tx),
    .uart_rx   (uart_rx),
    .ledout    (ledout)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 32; i++) prog[i] = 16'h0000;
  endtask

  // Assert reset, zero RAM, place prog[], hold reset 5 cycles.
  task automatic reset_load();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < MEM_WORDS; i++) dut.mem[i] <= 16'h0000;
    for (int i = 0; i < 32; i++) dut.mem[i] <= prog[i];
    repeat (5) @(negedge clk);
  endtask

  task automatic uart_send(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (4) @(negedge clk);
    end
    uart_rx = 1'b1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // ---------------- tests ----------------
  initial begin
    int cyc;
    logic [9:0] frame;
    logic [15:0] exp_stat, exp_data;

    // Reset state, then an all-zero image spins on "jump 0".
    clear_prog();
    reset_load();
    check("rst_pc",   16'(dut.u_core.pc_q),  16'h0000);
    check("rst_dsp",  16'(dut.u_core.dsp_q), 16'h0000);
    check("rst_rsp",  16'(dut.u_core.rsp_q), 16'h0000);
    check("rst_t",    dut.u_core.t_q,        16'h0000);
    check("rst_led",  16'(ledout),           16'h0000);
    check("rst_tx",   16'(uart_tx),          16'h0001);
    check("rst_busy", 16'(dut.tx_busy),      16'h0000);
    rst = 1'b0;
    step(10);
    check("idle_pc",  16'(dut.u_core.pc_q), 16'h0000);
    check("idle_led", 16'(ledout),          16'h0000);
    check("idle_tx",  16'(uart_tx),         16'h0001);

    // LED: lit 1, lit 0x7FFF, ~T (0x8000), store, [T] pushed.
    clear_prog();
    prog[0] = 16'h8001; prog[1] = 16'hFFFF; prog[2] = 16'h6600;
    prog[3] = 16'h6020; prog[4] = 16'h6C81; prog[5] = 16'h0005;
    reset_load();
    rst = 1'b0;
    step(3);
    check("led_before", 16'(ledout), 16'h0000);
    step(1);
    check("led_set", 16'(ledout), 16'h0001);
    step(2);
    check("led_readback", dut.u_core.t_q, 16'h0001);
    check("led_dsp", 16'(dut.u_core.dsp_q), 16'h0003);

    // ALU spot checks with N=0xFFFE, T=0x0001.
    clear_prog();
    prog[0]  = 16'h8001; prog[1]  = 16'h6600; prog[2]  = 16'h8001; prog[3]  = 16'h6800;
    prog[4]  = 16'h6103; prog[5]  = 16'h8001; prog[6]  = 16'h6F00;
    prog[7]  = 16'h6103; prog[8]  = 16'h8001; prog[9]  = 16'h6200;
    prog[10] = 16'h6103; prog[11] = 16'h8001; prog[12] = 16'h6700;
    prog[13] = 16'h6103; prog[14] = 16'h8001; prog[15] = 16'h6900;
    prog[16] = 16'h6103; prog[17] = 16'h8001; prog[18] = 16'h6D00;
    prog[19] = 16'h6E00; prog[20] = 16'h6A00; prog[21] = 16'h0015;
    reset_load();
    rst = 1'b0;
    step(4); check("alu_slt",   dut.u_core.t_q, 16'hFFFF);
    step(3); check("alu_ult",   dut.u_core.t_q, 16'h0000);
    step(3); check("alu_add",   dut.u_core.t_q, 16'hFFFF);
    step(3); check("alu_eq",    dut.u_core.t_q, 16'h0000);
    step(3); check("alu_rsh",   dut.u_core.t_q, 16'h7FFF);
    step(3); check("alu_lsh",   dut.u_core.t_q, 16'hFFFC);
    step(1); check("alu_depth", dut.u_core.t_q, 16'h0002);
    step(1); check("alu_dec",   dut.u_core.t_q, 16'h0001);

    // Taken cjump, call/return, not-taken cjump.
    clear_prog();
    prog[0] = 16'h8000; prog[1] = 16'h2003; prog[2] = 16'h0002; prog[3] = 16'h4008;
    prog[4] = 16'h8001; prog[5] = 16'h2002; prog[6] = 16'h0006; prog[7] = 16'h0007;
    prog[8] = 16'h9234; prog[9] = 16'h710F;
    reset_load();
    rst = 1'b0;
    exp_q = '{16'd1, 16'd3, 16'd8, 16'd9, 16'd4, 16'd5, 16'd6, 16'd6};
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("pc_trace", 16'(dut.u_core.pc_q), exp_q.pop_front());
      if (i == 3) check("call_lit", dut.u_core.t_q, 16'h1234);
    end
    check("flow_dsp", 16'(dut.u_core.dsp_q), 16'h0000);
    check("flow_rsp", 16'(dut.u_core.rsp_q), 16'h0000);
    check("flow_t",   dut.u_core.t_q,        16'h0000);

    // UART TX of 0x55; a second write while busy must be ignored.
    clear_prog();
    prog[0] = 16'h8055; prog[1] = 16'hFFFD; prog[2] = 16'h6600; prog[3] = 16'h6020;
    prog[4] = 16'h800F; prog[5] = 16'hFFFD; prog[6] = 16'h6600; prog[7] = 16'h6020;
    prog[8] = 16'h0008;
    reset_load();
    rst = 1'b0;
    cyc = 0;
    while (uart_tx === 1'b1 && cyc < 20) begin
      step(1);
      cyc++;
    end
    check("tx_start_lat", 16'(cyc), 16'd4);
    frame = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 40; i++) begin
      check("tx_bit",  16'(uart_tx),     16'(frame[i / 4]));
      check("tx_busy", 16'(dut.tx_busy), 16'h0001);
      step(1);
    end
    check("tx_done_busy", 16'(dut.tx_busy), 16'h0000);
    check("tx_done_line", 16'(uart_tx),     16'h0001);
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("tx_stay_idle", 16'(uart_tx), 16'h0001);
    end

    // Reset in the middle of a frame.
    reset_load();
    rst = 1'b0;
    step(14);
    check("txm_bit1", 16'(uart_tx), 16'h0000);
    rst = 1'b1;
    step(1);
    check("txr_line", 16'(uart_tx),          16'h0001);
    check("txr_busy", 16'(dut.tx_busy),      16'h0000);
    check("txr_pc",   16'(dut.u_core.pc_q),  16'h0000);
    check("txr_ram",  dut.mem[0],            16'h8055);

    // UART RX of 0xA3 at 4 clocks/bit, then status / data / status via CPU.
`ifdef J1SOC_UART_RX_EN
    exp_stat = 16'h0002;
    exp_data = 16'h00A3;
`else
    exp_stat = 16'h0000;
    exp_data = 16'h0000;
`endif
    clear_prog();
    prog[0] = 16'hFFFB; prog[1] = 16'h6600; prog[2] = 16'h0002;
    reset_load();
    rst = 1'b0;
    step(5);
    uart_send(8'hA3);
    step(10);
    dut.mem[2] <= 16'h6C81; dut.mem[3] <= 16'hFFF9; dut.mem[4] <= 16'h6600;
    dut.mem[5] <= 16'h6C00; dut.mem[6] <= 16'hFFFB; dut.mem[7] <= 16'h6600;
    dut.mem[8] <= 16'h6C00; dut.mem[9] <= 16'h0009;
    step(1);
    check("rx_status", dut.u_core.t_q, exp_stat);
    step(3);
    check("rx_data", dut.u_core.t_q, exp_data);
    step(3);
    check("rx_status_clr", dut.u_core.t_q, 16'h0000);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
